// File: rtl/multi_debouncer.sv
// multi_debouncer: N-channel synchronise/debounce with rise, fall and auto-repeat press strobes
module multi_debouncer #(
    parameter int CHANNELS      = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 500000,
    parameter int REPEAT_EN     = 0,
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_PERIOD = 5000000
) (
    input  logic                CLOCK,
    input  logic                Reset_n,
    input  logic [CHANNELS-1:0] InputPulse,
    output logic [CHANNELS-1:0] DebouncedOutput,
    output logic [CHANNELS-1:0] Rise,
    output logic [CHANNELS-1:0] Fall,
    output logic [CHANNELS-1:0] Press
);
    typedef enum logic [1:0] {LOW_STABLE, LOW_TO_HIGH, HIGH_STABLE, HIGH_TO_LOW} state_t;
    localparam int MAX_RPT = REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int MAX_CNT = STABLE_CYCLES > MAX_RPT ? STABLE_CYCLES : MAX_RPT;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);
    genvar i;
    generate
        for (i = 0; i < CHANNELS; i++) begin : gCh
            logic [SYNC_STAGES-1:0] syncReg;
            logic                   s;
            state_t                 state, stateNext;
            logic [CNT_W-1:0]       cnt, cntNext;
            logic                   riseNext, fallNext, repeatHit;
            logic                   dbReg, riseReg, fallReg, pressReg;
            assign s = syncReg[SYNC_STAGES-1];
            // shift the raw pin level through the synchroniser chain
            always_ff @(posedge CLOCK or negedge Reset_n) begin
                if (!Reset_n) syncReg <= '0;
                else          syncReg <= {syncReg[SYNC_STAGES-2:0], InputPulse[i]};
            end
            // state, stability counter and registered level/strobe outputs
            always_ff @(posedge CLOCK or negedge Reset_n) begin
                if (!Reset_n) begin
                    state    <= LOW_STABLE;
                    cnt      <= '0;
                    dbReg    <= 1'b0;
                    riseReg  <= 1'b0;
                    fallReg  <= 1'b0;
                    pressReg <= 1'b0;
                end else begin
                    state    <= stateNext;
                    cnt      <= cntNext;
                    dbReg    <= riseNext ? 1'b1 : fallNext ? 1'b0 : dbReg;
                    riseReg  <= riseNext;
                    fallReg  <= fallNext;
                    pressReg <= riseNext | repeatHit;
                end
            end
            // next state: count consecutive cycles at the opposite level, any gap restarts
            always_comb begin
                stateNext = state;
                cntNext   = '0;
                riseNext  = 1'b0;
                fallNext  = 1'b0;
                case (state)
                    LOW_STABLE: if (s) begin
                        stateNext = LOW_TO_HIGH;
                        cntNext   = CNT_W'(1);
                    end
                    LOW_TO_HIGH: if (!s) stateNext = LOW_STABLE;
                    else if (cnt == CNT_W'(STABLE_CYCLES - 1)) begin
                        stateNext = HIGH_STABLE;
                        riseNext  = 1'b1;
                    end else cntNext = cnt + CNT_W'(1);
                    HIGH_STABLE: if (!s) begin
                        stateNext = HIGH_TO_LOW;
                        cntNext   = CNT_W'(1);
                    end
                    HIGH_TO_LOW: if (s) stateNext = HIGH_STABLE;
                    else if (cnt == CNT_W'(STABLE_CYCLES - 1)) begin
                        stateNext = LOW_STABLE;
                        fallNext  = 1'b1;
                    end else cntNext = cnt + CNT_W'(1);
                    default: stateNext = LOW_STABLE;
                endcase
            end
            if (REPEAT_EN != 0) begin : gRep
                logic [CNT_W-1:0] rptCnt;
                logic             rptFirst;
                assign repeatHit = dbReg && !fallNext &&
                                   rptCnt == (rptFirst ? CNT_W'(REPEAT_DELAY) : CNT_W'(REPEAT_PERIOD));
                // time since Rise (first gap) or since the last repeat strobe (later gaps)
                always_ff @(posedge CLOCK or negedge Reset_n) begin
                    if (!Reset_n) begin
                        rptCnt   <= '0;
                        rptFirst <= 1'b0;
                    end else if (riseNext) begin
                        rptCnt   <= CNT_W'(1);
                        rptFirst <= 1'b1;
                    end else if (!dbReg || fallNext) begin
                        rptCnt   <= '0;
                        rptFirst <= 1'b0;
                    end else if (repeatHit) begin
                        rptCnt   <= CNT_W'(1);
                        rptFirst <= 1'b0;
                    end else rptCnt <= rptCnt + CNT_W'(1);
                end
            end else begin : gNoRep
                assign repeatHit = 1'b0;
            end
            assign DebouncedOutput[i] = dbReg;
            assign Rise[i]            = riseReg;
            assign Fall[i]            = fallReg;
            assign Press[i]           = pressReg;
        end
    endgenerate
endmodule

// File: tb/tb_multi_debouncer.sv
// tb_multi_debouncer: directed and random stimulus against a run-length/age reference model
module tb_multi_debouncer;
    localparam int ST = 4;
    localparam int RD = 10;
    localparam int RP = 3;
    logic       CLOCK = 1'b0;
    logic       Reset_n;
    logic [1:0] InputPulse;
    logic [1:0] DebouncedOutput, Rise, Fall, Press;
    int checks = 0;
    int errors = 0;
    logic [1:0] pin1, pin2, mDb, mRise, mFall, mPress;
    int run [2];
    int age [2];

    multi_debouncer #(
        .CHANNELS(2), .SYNC_STAGES(2), .STABLE_CYCLES(ST),
        .REPEAT_EN(1), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut (
        .CLOCK(CLOCK), .Reset_n(Reset_n), .InputPulse(InputPulse),
        .DebouncedOutput(DebouncedOutput), .Rise(Rise), .Fall(Fall), .Press(Press)
    );

    always #5 CLOCK = ~CLOCK;

    task automatic modelReset();
        pin1 = 0; pin2 = 0; mDb = 0; mRise = 0; mFall = 0; mPress = 0;
        for (int c = 0; c < 2; c++) begin run[c] = 0; age[c] = 0; end
    endtask

    // one clock edge: pin2 is the synchronised level seen by the debouncer
    task automatic modelEdge(input logic [1:0] v);
        for (int c = 0; c < 2; c++) begin
            mRise[c] = 0; mFall[c] = 0; mPress[c] = 0;
            if (pin2[c] != mDb[c]) begin
                run[c]++;
                if (run[c] == ST) begin
                    mDb[c] = pin2[c]; run[c] = 0;
                    mRise[c] = mDb[c]; mFall[c] = !mDb[c];
                end
            end else run[c] = 0;
            if (mRise[c]) age[c] = 0;
            else if (mDb[c]) begin
                age[c]++;
                mPress[c] = (age[c] == RD) || (age[c] > RD && (age[c] - RD) % RP == 0);
            end
            mPress[c] = mPress[c] | mRise[c];
        end
        pin2 = pin1; pin1 = v;
    endtask

    task automatic check(input string tag);
        checks++;
        assert (DebouncedOutput === mDb) else begin errors++; $error("FAIL %s DebouncedOutput observed %b expected %b", tag, DebouncedOutput, mDb); end
        checks++;
        assert (Rise === mRise) else begin errors++; $error("FAIL %s Rise observed %b expected %b", tag, Rise, mRise); end
        checks++;
        assert (Fall === mFall) else begin errors++; $error("FAIL %s Fall observed %b expected %b", tag, Fall, mFall); end
        checks++;
        assert (Press === mPress) else begin errors++; $error("FAIL %s Press observed %b expected %b", tag, Press, mPress); end
    endtask

    task automatic expectInt(input string tag, input int got, input int want);
        checks++;
        assert (got === want) else begin errors++; $error("FAIL %s observed %0d expected %0d", tag, got, want); end
    endtask

    task automatic tick(input logic [1:0] v, input string tag);
        InputPulse = v;
        @(posedge CLOCK);
        if (Reset_n) modelEdge(v); else modelReset();
        #1;
        check(tag);
    endtask

    initial begin
        int seen;
        int cnt;
        logic [1:0] lvl;
        Reset_n = 1'b0;
        InputPulse = 2'b11;
        modelReset();
        for (int k = 0; k < 3; k++) tick(2'b11, "reset_hold");
        Reset_n = 1'b1;
        seen = 0;
        for (int k = 1; k <= 8; k++) begin
            tick(2'b11, "release");
            if (Rise[0] && seen == 0) seen = k;
        end
        expectInt("release_rise_edge", seen, 6);
        for (int k = 0; k < 30; k++) tick(2'b11, "repeat_hold");
        seen = 0;
        for (int k = 1; k <= 8; k++) begin
            tick(2'b10, "ch0_release");
            if (Fall[0] && seen == 0) seen = k;
        end
        expectInt("ch0_fall_edge", seen, 6);
        cnt = $urandom_range(1, 3);
        for (int k = 0; k < cnt; k++) tick(2'b11, "glitch_high");
        for (int k = 0; k < 6; k++) tick(2'b10, "glitch_low");
        seen = 0;
        for (int k = 1; k <= 8; k++) begin
            tick(k <= 4 ? 2'b11 : 2'b10, "four_cycle_high");
            if (Rise[0] && seen == 0) seen = k;
        end
        expectInt("four_cycle_rise_edge", seen, 6);
        for (int k = 0; k < 10; k++) tick(2'b10, "ch0_low");
        for (int k = 0; k < 8; k++) tick(2'b11, "ch0_high");
        seen = 0;
        for (int k = 1; k <= 12; k++) begin
            tick(k == 3 ? 2'b11 : 2'b10, "blip_release");
            if (Fall[0] && seen == 0) seen = k;
        end
        expectInt("blip_fall_edge", seen, 9);
        seen = 0;
        cnt = 0;
        for (int k = 1; k <= 12; k++) begin
            tick(2'b00, "ch1_release");
            if (Fall[1]) seen = k;
            if (seen != 0 && Press[1]) cnt++;
        end
        expectInt("ch1_fall_seen", int'(seen != 0), 1);
        expectInt("ch1_press_after_fall", cnt, 0);
        seen = 0;
        cnt = 0;
        for (int k = 1; k <= 12; k++) begin
            tick({1'(((k - 1) / 2) % 2), 1'b1}, "independence");
            if (Rise[0] && seen == 0) seen = k;
            if (Rise[1] || Fall[1] || Press[1] || DebouncedOutput[1]) cnt++;
        end
        expectInt("indep_ch0_rise_edge", seen, 6);
        expectInt("indep_ch1_quiet", cnt, 0);
        lvl = 2'b01;
        for (int k = 0; k < 400; k++) begin
            for (int c = 0; c < 2; c++) if ($urandom_range(0, 5) == 0) lvl[c] = ~lvl[c];
            tick(lvl, "random");
        end
        for (int k = 0; k < 20; k++) tick(2'b11, "pre_reset_hold");
        expectInt("pre_reset_level", int'(DebouncedOutput), 3);
        Reset_n = 1'b0;
        #1;
        modelReset();
        check("async_reset");
        for (int k = 0; k < 2; k++) tick(2'b11, "reset_mid_repeat");
        Reset_n = 1'b1;
        seen = 0;
        cnt = 0;
        for (int k = 1; k <= 8; k++) begin
            tick(2'b11, "rerelease");
            if (Rise[0] && seen == 0) seen = k;
            if (k < 6 && (Press != 2'b00 || Rise != 2'b00)) cnt++;
        end
        expectInt("rerelease_rise_edge", seen, 6);
        expectInt("rerelease_no_early_strobe", cnt, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/multi_debouncer.md
Name: multi_debouncer

Overview:
Parametrised N-channel switch/button debouncer replacing the single-channel Debouncer/DelayLoop pair. Per channel: synchroniser, integrated stability counter (no external timer), registered level output, one-cycle rise/fall strobes and an optional auto-repeat press strobe for held buttons (paddle controls). Sits between board pins and game control logic; all outputs are synchronous to CLOCK.

Parameters:
CHANNELS, 4, number of independent input channels (>=1)
SYNC_STAGES, 2, synchroniser flops per channel (>=2)
STABLE_CYCLES, 500000, consecutive synchronised cycles at new level required to accept a change (>=2)
REPEAT_EN, 0, 1 enables auto-repeat on Press
REPEAT_DELAY, 25000000, cycles from Rise to first repeat strobe (>=1)
REPEAT_PERIOD, 5000000, cycles between subsequent repeat strobes (>=1)

Ports:
CLOCK  input  1  system clock
Reset_n  input  1  asynchronous active-low reset
InputPulse  input  CHANNELS  raw asynchronous switch levels
DebouncedOutput  output  CHANNELS  debounced level per channel
Rise  output  CHANNELS  one-cycle strobe: DebouncedOutput went 0->1
Fall  output  CHANNELS  one-cycle strobe: DebouncedOutput went 1->0
Press  output  CHANNELS  Rise plus auto-repeat strobes (equals Rise when REPEAT_EN=0)

Behaviour:
- Reset (Reset_n low, async assert, sync release): all sync flops, counters, DebouncedOutput, Rise, Fall, Press = 0; FSM in LOW_STABLE.
- Channels fully independent; identical logic generated per channel.
- Sync: InputPulse[i] through SYNC_STAGES flops -> s[i]. Only s[i] used downstream.
- Per-channel FSM states: LOW_STABLE, LOW_TO_HIGH, HIGH_STABLE, HIGH_TO_LOW.
  - LOW_STABLE: s=1 -> LOW_TO_HIGH, cnt<=1; else stay, cnt<=0.
  - LOW_TO_HIGH: s=0 -> LOW_STABLE, cnt<=0 (glitch rejected, no strobe). s=1 and cnt==STABLE_CYCLES-1 -> HIGH_STABLE, DebouncedOutput<=1, Rise<=1, cnt<=0. Else cnt++.
  - HIGH_STABLE / HIGH_TO_LOW: mirror image, producing DebouncedOutput<=0, Fall<=1.
- Latency: s held constant for exactly STABLE_CYCLES cycles -> DebouncedOutput changes on the edge ending the STABLE_CYCLES-th cycle; pin-to-output = SYNC_STAGES + STABLE_CYCLES edges. A gap of even one cycle restarts the count.
- Counter width = $clog2(max(STABLE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)+1); no wrap possible (cleared at terminal count).
- Rise/Fall registered, high for exactly one cycle, coincident with the DebouncedOutput edge; never both high on one channel.
- Repeat (REPEAT_EN=1): separate per-channel repeat counter, cleared on Rise. While in HIGH_STABLE or HIGH_TO_LOW: Press pulses REPEAT_DELAY cycles after Rise, then every REPEAT_PERIOD cycles. Counter cleared and strobes stop the cycle DebouncedOutput falls. Press = Rise OR repeat strobe; one cycle each.
- REPEAT_EN=0: repeat logic not generated; Press = Rise.
- Reset mid-count or mid-repeat: immediate return to reset values; no strobe emitted on release even if input high (requires fresh full STABLE_CYCLES).
- Simultaneous changes on multiple channels handled in parallel, no arbitration.

Test Plan:
(Bench params: CHANNELS=2, SYNC_STAGES=2, STABLE_CYCLES=4, REPEAT_EN=1, REPEAT_DELAY=10, REPEAT_PERIOD=3.)
- Reset: hold Reset_n=0 with InputPulse=2'b11 -> all outputs 0; release, keep 1 -> DebouncedOutput[0] rises exactly 6 edges later with one-cycle Rise[0]=1, Press[0]=1.
- Glitch: ch0 pulse high 3 cycles then low -> DebouncedOutput, Rise, Press stay 0; then high 4 cycles -> Rise after 2+4 edges.
- Release: after stable high, drive ch0 low -> Fall[0] one cycle 6 edges later, DebouncedOutput[0]=0; 1-cycle high blip during countdown restarts count (Fall delayed accordingly).
- Auto-repeat: hold ch1 high 30 cycles past Rise -> Press[1] at Rise, Rise+10, +13, +16, ... ; release -> no Press after DebouncedOutput[1] falls.
- Independence: ch0 rises while ch1 bounces with 2-cycle pulses -> ch0 strobes at expected edge, ch1 outputs unchanged.
- Async reset mid-repeat: assert Reset_n between repeat strobes -> outputs 0 immediately (before next CLOCK edge); no spurious strobe after release until full 6-edge qualification.
